// File: rtl/seq_detector_sipo_pkg.sv
// Shared constants and helpers for the serial pattern detector and its neighbours.
package seq_detector_sipo_pkg;

  localparam int unsigned DEF_PAT_LEN = 4;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1011;

  // Bits needed to count 0..pat_len inclusive.
  function automatic int unsigned fill_width(input int unsigned pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out register: newest bit enters the LSB on enable.
module sipo_shift_reg #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (en) begin
      q <= {q[W-2:0], din};
    end
  end

endmodule

// File: rtl/seq_detector_sipo.sv
// Serial pattern detector: history shift register, fill tracking, detect pulse, saturating match count.
module seq_detector_sipo
  import seq_detector_sipo_pkg::*;
#(
  parameter int unsigned           PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0]    PATTERN = DEF_PATTERN,
  parameter bit                    OVERLAP = 1'b1,
  parameter int unsigned           CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din_valid,
  input  logic               din,
  input  logic               clear,
  output logic               detect,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [PAT_LEN-1:0] hist
);

  localparam int unsigned      FILL_W  = fill_width(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_d;
  logic [FILL_W-1:0]  next_fill;
  logic [PAT_LEN-1:0] next_hist;
  logic [CNT_W-1:0]   cnt_d;
  logic               hit;

  sipo_shift_reg #(.W(PAT_LEN)) u_hist (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .en    (din_valid),
    .din   (din),
    .q     (hist)
  );

  // A hit needs a full history since the last reset/clear, not just a matching value.
  always_comb begin
    next_hist = {hist[PAT_LEN-2:0], din};
    next_fill = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
    hit       = din_valid && (next_fill == FILL_MAX) && (next_hist == PATTERN);
    fill_d    = fill;
    cnt_d     = match_cnt;
    if (din_valid) begin
      fill_d = (hit && !OVERLAP) ? '0 : next_fill;
    end
    if (hit && (match_cnt != CNT_MAX)) begin
      cnt_d = match_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill      <= '0;
      match_cnt <= '0;
      detect    <= 1'b0;
    end else if (clear) begin
      fill      <= '0;
      match_cnt <= '0;
      detect    <= 1'b0;
    end else begin
      fill      <= fill_d;
      match_cnt <= cnt_d;
      detect    <= hit;
    end
  end

endmodule

// File: tb/tb_seq_detector_sipo.sv
// Directed bench: overlapping, non-overlapping and 2-bit-counter detectors share one stimulus stream.
module tb_seq_detector_sipo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din_valid = 1'b0;
  logic din = 1'b0;
  logic clear = 1'b0;

  logic       det_o, det_n, det_s;
  logic [7:0] cnt_o, cnt_n;
  logic [1:0] cnt_s;
  logic [3:0] hist_o, hist_n, hist_s;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detector_sipo u_ovl (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clear(clear),
    .detect(det_o), .match_cnt(cnt_o), .hist(hist_o)
  );

  seq_detector_sipo #(.OVERLAP(1'b0)) u_nov (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clear(clear),
    .detect(det_n), .match_cnt(cnt_n), .hist(hist_n)
  );

  seq_detector_sipo #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clear(clear),
    .detect(det_s), .match_cnt(cnt_s), .hist(hist_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic d);
    din_valid = v;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1'b0, 1'b0);
    clear = 1'b0;
  endtask

  initial begin
    logic [6:0]  s7;
    logic [6:0]  e_ovl;
    logic [6:0]  e_nov;
    logic [15:0] s16;
    logic [15:0] e16;
    logic [3:0]  m_hist;
    int          hits;

    // Reset state
    do_reset();
    chk("rst_hist", 32'(hist_o), 32'h0);
    chk("rst_cnt", 32'(cnt_o), 32'h0);
    chk("rst_det", 32'(det_o), 32'h0);

    // Overlap vs non-overlap on 1,0,1,1,0,1,1
    s7 = 7'b1011011;
    e_ovl = 7'b0001001;
    e_nov = 7'b0001000;
    m_hist = 4'b0000;
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, s7[i]);
      m_hist = {m_hist[2:0], s7[i]};
      chk($sformatf("ovl_det_b%0d", 7 - i), 32'(det_o), 32'(e_ovl[i]));
      chk($sformatf("nov_det_b%0d", 7 - i), 32'(det_n), 32'(e_nov[i]));
      chk($sformatf("ovl_hist_b%0d", 7 - i), 32'(hist_o), 32'(m_hist));
    end
    chk("ovl_cnt", 32'(cnt_o), 32'd2);
    chk("ovl_hist_final", 32'(hist_o), 32'hB);
    chk("nov_cnt", 32'(cnt_n), 32'd1);
    chk("nov_hist_final", 32'(hist_n), 32'hB);
    chk("nov_fill", 32'(u_nov.fill), 32'd3);

    // Gaps: 1,0, three invalid cycles with toggling din, then 1,1
    do_clear();
    chk("clr_cnt", 32'(cnt_o), 32'h0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'((i + 1) % 2));
      chk($sformatf("gap_hist_%0d", i), 32'(hist_o), 32'h2);
      chk($sformatf("gap_det_%0d", i), 32'(det_o), 32'h0);
    end
    step(1'b1, 1'b1);
    chk("gap_det_b3", 32'(det_o), 32'h0);
    chk("gap_hist_b3", 32'(hist_o), 32'h5);
    step(1'b1, 1'b1);
    chk("gap_det_b4", 32'(det_o), 32'h1);
    chk("gap_cnt", 32'(cnt_o), 32'h1);
    step(1'b0, 1'b0);
    chk("gap_det_after", 32'(det_o), 32'h0);

    // Saturation of the 2-bit counter: five overlapping hits
    do_clear();
    s16 = 16'b1011011011011011;
    e16 = 16'b0001001001001001;
    hits = 0;
    for (int i = 15; i >= 0; i--) begin
      step(1'b1, s16[i]);
      if (e16[i]) hits++;
      chk($sformatf("sat_det_b%0d", 16 - i), 32'(det_s), 32'(e16[i]));
      chk($sformatf("sat_cnt_b%0d", 16 - i), 32'(cnt_s), 32'((hits > 3) ? 3 : hits));
    end
    chk("sat_wide_cnt", 32'(cnt_o), 32'd5);

    // Reset mid-stream discards partial bits
    do_clear();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    do_reset();
    chk("mid_rst_hist", 32'(hist_o), 32'h0);
    step(1'b1, 1'b1);
    chk("mid_rst_det", 32'(det_o), 32'h0);
    chk("mid_rst_hist1", 32'(hist_o), 32'h1);
    chk("mid_rst_cnt", 32'(cnt_o), 32'h0);

    // Reset while din_valid=1 drops that bit
    step(1'b1, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b1);
    rst_n = 1'b1;
    chk("rst_valid_hist", 32'(hist_o), 32'h0);
    chk("rst_valid_det", 32'(det_o), 32'h0);
    step(1'b1, 1'b1);
    chk("rst_valid_hist1", 32'(hist_o), 32'h1);

    // Clear has priority over an accepted bit
    do_reset();
    s7 = 7'b1011010;
    for (int i = 6; i >= 0; i--) step(1'b1, s7[i]);
    chk("pre_clr_hist", 32'(hist_n), 32'hA);
    chk("pre_clr_fill", 32'(u_nov.fill), 32'd3);
    clear = 1'b1;
    step(1'b1, 1'b1);
    clear = 1'b0;
    chk("clr_pri_det", 32'(det_n), 32'h0);
    chk("clr_pri_hist", 32'(hist_n), 32'h0);
    chk("clr_pri_cnt", 32'(cnt_n), 32'h0);
    chk("clr_pri_ovl_cnt", 32'(cnt_o), 32'h0);
    hits = 0;
    s7 = 7'b0001011;
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, s7[i]);
      hits += int'(det_n);
    end
    chk("post_clr_hits", 32'(hits), 32'd1);
    chk("post_clr_det", 32'(det_n), 32'h1);
    chk("post_clr_cnt", 32'(cnt_n), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
